// File: rtl/fifo_deq_serializer.sv
`timescale 1ns/1ps
// fifo_deq_serializer
//   Drains a one-entry FIFO through its first/deq method pair. Each wide
//   element is sent out as BEATS narrow beats on an enq-style ENA/RDY port,
//   least-significant beat first. The deq of the next element happens in the
//   same cycle as the last beat of the current one, so back-to-back elements
//   stream with no bubble between them.
//
// Ports
//   CLK, nRST      clock (posedge) and asynchronous active-low reset
//   in_first       head element of the upstream FIFO
//   in_first__RDY  head element is valid
//   in_deq__RDY    upstream deq may fire
//   in_deq__ENA    deq the upstream head this cycle (combinational)
//   out_enq_v      current beat
//   out_enq__ENA   beat transferred this cycle
//   out_enq__RDY   downstream can accept a beat
//   busy           an element is held and beats are still outstanding
//   elems_done     count of fully transmitted elements (wraps)

module fifo_deq_serializer #(
  parameter int DATA_WIDTH = 384,
  parameter int BEAT_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [DATA_WIDTH-1:0] in_first,
  input  logic                  in_first__RDY,
  input  logic                  in_deq__RDY,
  output logic                  in_deq__ENA,
  output logic [BEAT_WIDTH-1:0] out_enq_v,
  output logic                  out_enq__ENA,
  input  logic                  out_enq__RDY,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  elems_done
);

  localparam int BEATS      = DATA_WIDTH / BEAT_WIDTH;
  localparam int BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // An element must split into a whole number of beats.
  if ((DATA_WIDTH % BEAT_WIDTH) != 0) begin : g_width_check
    $error("fifo_deq_serializer: DATA_WIDTH must be a multiple of BEAT_WIDTH");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e                st_q, st_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BEAT_IDX_W-1:0] beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  elems_done_q, elems_done_d;

  logic avail;
  logic sending;
  logic last;
  logic deq_fire;

  always_comb begin
    avail   = in_first__RDY & in_deq__RDY;
    sending = (st_q == ST_SEND);
    last    = sending & (beat_q == BEAT_IDX_W'(BEATS - 1)) & out_enq__RDY;
    // The flops already read IDLE during reset, but avail would still pass
    // through combinationally; gating with nRST keeps the deq strobe quiet.
    deq_fire = nRST & avail & (~sending | last);
  end

  // NOTE: every variable assigned in an always_comb gets a default first so
  // no path leaves it unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    st_d         = st_q;
    shreg_d      = shreg_q;
    beat_d       = beat_q;
    elems_done_d = elems_done_q;

    unique case (st_q)
      ST_IDLE: begin
        if (deq_fire) begin
          shreg_d = in_first;
          beat_d  = '0;
          st_d    = ST_SEND;
        end
      end

      ST_SEND: begin
        // out_enq__RDY low: everything holds, so no beat is lost or repeated.
        if (out_enq__RDY) begin
          if (last) begin
            elems_done_d = elems_done_q + CNT_WIDTH'(1);
            beat_d       = '0;
            if (deq_fire) begin
              // Next element loaded while its predecessor's last beat leaves.
              shreg_d = in_first;
            end else begin
              // Cleared on drain so out_enq_v reads zero while idle.
              shreg_d = '0;
              st_d    = ST_IDLE;
            end
          end else begin
            shreg_d = shreg_q >> BEAT_WIDTH;
            beat_d  = beat_q + BEAT_IDX_W'(1);
          end
        end
      end

      default: st_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order across blocks.
  // NOTE: shreg is a datapath register rather than a memory, and it is reset
  // because out_enq_v is taken straight from it and must read zero in reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      st_q         <= ST_IDLE;
      shreg_q      <= '0;
      beat_q       <= '0;
      elems_done_q <= '0;
    end else begin
      st_q         <= st_d;
      shreg_q      <= shreg_d;
      beat_q       <= beat_d;
      elems_done_q <= elems_done_d;
    end
  end

  assign in_deq__ENA  = deq_fire;
  assign out_enq__ENA = sending & out_enq__RDY;
  assign out_enq_v    = shreg_q[BEAT_WIDTH-1:0];
  assign busy         = sending;
  assign elems_done   = elems_done_q;

endmodule

// File: tb/tb_fifo_deq_serializer.sv
`timescale 1ns/1ps
// Testbench for fifo_deq_serializer. A transaction-level model keeps the
// number of beats still owed for the current element and the completed
// element count; every predicted deq pushes that element's beats into a
// scoreboard queue, which a separate monitor drains as beats appear.
// The small counter width makes the completed-element count wrap.

module tb_fifo_deq_serializer;

  localparam int DW = 384;
  localparam int BW = 32;
  localparam int CW = 2;
  localparam int NB = DW / BW;

  logic          clk = 1'b0;
  logic          nrst;
  logic [DW-1:0] in_first;
  logic          in_first_rdy;
  logic          in_deq_rdy;
  logic          in_deq_ena;
  logic [BW-1:0] out_v;
  logic          out_ena;
  logic          out_rdy;
  logic          busy;
  logic [CW-1:0] elems_done;

  always #5 clk = ~clk;

  fifo_deq_serializer #(
    .DATA_WIDTH(DW),
    .BEAT_WIDTH(BW),
    .CNT_WIDTH (CW)
  ) dut (
    .CLK          (clk),
    .nRST         (nrst),
    .in_first     (in_first),
    .in_first__RDY(in_first_rdy),
    .in_deq__RDY  (in_deq_rdy),
    .in_deq__ENA  (in_deq_ena),
    .out_enq_v    (out_v),
    .out_enq__ENA (out_ena),
    .out_enq__RDY (out_rdy),
    .busy         (busy),
    .elems_done   (elems_done)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard of beats owed to the downstream channel, in order.
  logic [BW-1:0] sb_q[$];
  // Reference model: beats left in the current element, completed elements.
  int rem  = 0;
  int done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] make_elem(input int base);
    logic [DW-1:0] e;
    for (int i = 0; i < NB; i++) e[i*BW +: BW] = BW'(base + i);
    return e;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: predicts control outputs each cycle and issues expected beats.
  always @(negedge clk) begin
    logic busy_m;
    logic exp_deq;
    if (!nrst) begin
      check("rst_deq_ena", in_deq_ena, 0);
      check("rst_out_ena", out_ena, 0);
      check("rst_out_v", out_v, 0);
      check("rst_busy", busy, 0);
      check("rst_elems_done", elems_done, 0);
    end else begin
      busy_m  = (rem > 0);
      exp_deq = in_first_rdy && in_deq_rdy && (!busy_m || (rem == 1 && out_rdy));
      check("busy", busy, busy_m);
      check("out_ena", out_ena, busy_m && out_rdy);
      check("deq_ena", in_deq_ena, exp_deq);
      check("elems_done", elems_done, done);
      if (!busy_m) check("idle_out_v", out_v, 0);
      if (busy_m && out_rdy) begin
        rem--;
        if (rem == 0) done = (done + 1) % (1 << CW);
      end
      if (exp_deq) begin
        rem = NB;
        for (int i = 0; i < NB; i++) sb_q.push_back(in_first[i*BW +: BW]);
      end
    end
  end

  // Monitor: compares every transferred beat, and stalled beats for stability.
  always @(negedge clk) begin
    logic [BW-1:0] exp_beat;
    if (nrst) begin
      if (out_ena) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got %0h expected no beat (t=%0t)", out_v, $time);
        end else begin
          exp_beat = sb_q.pop_front();
          check("beat", out_v, exp_beat);
        end
      end else if (busy && sb_q.size() > 0) begin
        check("stall_hold", out_v, sb_q[0]);
      end
    end
  end

  initial begin
    // 1: reset held with every ready high.
    nrst         = 1'b0;
    in_first     = make_elem(0);
    in_first_rdy = 1'b1;
    in_deq_rdy   = 1'b1;
    out_rdy      = 1'b1;
    cyc(3);
    in_first_rdy = 1'b0;
    in_deq_rdy   = 1'b0;
    nrst         = 1'b1;
    cyc(2);

    // 2: single element, beat i = i.
    in_first     = make_elem(0);
    in_first_rdy = 1'b1;
    in_deq_rdy   = 1'b1;
    cyc(1);
    in_first_rdy = 1'b0;
    in_deq_rdy   = 1'b0;
    cyc(14);
    check("single_done", elems_done, 1);
    check("single_idle", busy, 0);

    // 3: backpressure pattern 1,0,0,1,0,0,...
    in_first     = make_elem(200);
    in_first_rdy = 1'b1;
    in_deq_rdy   = 1'b1;
    cyc(1);
    in_first_rdy = 1'b0;
    in_deq_rdy   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      out_rdy = (k % 3 == 0);
      cyc(1);
    end
    out_rdy = 1'b1;
    cyc(2);
    check("bp_done", elems_done, 2);

    // 4: back-to-back elements, second loaded as the first's last beat leaves.
    in_first     = make_elem(0);
    in_first_rdy = 1'b1;
    in_deq_rdy   = 1'b1;
    cyc(1);
    in_first = make_elem(100);
    cyc(12);
    in_first_rdy = 1'b0;
    in_deq_rdy   = 1'b0;
    cyc(14);
    check("b2b_done_wrapped", elems_done, 0);

    // 5: asynchronous reset after beat 5, asserted and released between edges.
    in_first     = make_elem(300);
    in_first_rdy = 1'b1;
    in_deq_rdy   = 1'b1;
    cyc(1);
    in_first_rdy = 1'b0;
    in_deq_rdy   = 1'b0;
    cyc(6);
    #1;
    in_first     = make_elem(400);
    in_first_rdy = 1'b1;
    in_deq_rdy   = 1'b1;
    nrst         = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_out_ena", out_ena, 0);
    check("midrst_out_v", out_v, 0);
    check("midrst_deq_ena", in_deq_ena, 0);
    check("midrst_elems_done", elems_done, 0);
    rem  = 0;
    done = 0;
    sb_q.delete();
    #1;
    nrst = 1'b1;
    cyc(1);
    in_first_rdy = 1'b0;
    in_deq_rdy   = 1'b0;
    cyc(14);
    check("midrst_restart_done", elems_done, 1);

    // 6: randomized traffic; the 2-bit counter wraps many times.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NB; i++) in_first[i*BW +: BW] = $urandom;
      in_first_rdy = ($urandom_range(0, 3) != 0);
      in_deq_rdy   = ($urandom_range(0, 3) != 0);
      out_rdy      = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    in_first_rdy = 1'b0;
    in_deq_rdy   = 1'b0;
    out_rdy      = 1'b1;
    cyc(15);
    check("drain_sb_empty", sb_q.size(), 0);
    check("drain_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
